// File: rtl/calc_sequencer.sv
// Keypad-driven calculator controller: collects two 2-digit operands and an operator,
// launches the shared arithmetic unit via start/done, and holds the displayed value.
module calc_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 64,
  parameter int unsigned TMR_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [6:0]  alu_a,
  output logic [6:0]  alu_b,
  input  logic        alu_done,
  input  logic        alu_err,
  input  logic [13:0] alu_result,
  output logic [13:0] disp_value,
  output logic        disp_neg,
  output logic        disp_err,
  output logic        busy
);

  localparam int unsigned OPND_W = 7;
  localparam int unsigned RES_W  = 14;
  localparam int unsigned OP_W   = 2;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {S_A, S_B, S_EXEC, S_SHOW, S_ERR} state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [OPND_W-1:0] a, b;
  logic [OP_W-1:0]   op;
  logic              neg;
  logic [TMR_W-1:0]  tmr;

  logic              is_digit_c, is_op_c, is_eq_c, is_clr_c, small_res_c;
  logic [OP_W-1:0]   key_op_c;
  logic [OPND_W-1:0] digit_c, acc_c;

  // Key decode and next operand value for a second digit
  always_comb begin
    is_digit_c  = key_valid && (key_code < 8'h0A);
    is_eq_c     = key_valid && (key_code == 8'h48);
    is_clr_c    = key_valid && (key_code == 8'h18);
    is_op_c     = 1'b0;
    key_op_c    = 2'b00;
    case (key_code)
      8'h82:   begin is_op_c = key_valid; key_op_c = 2'b00; end
      8'h84:   begin is_op_c = key_valid; key_op_c = 2'b01; end
      8'h88:   begin is_op_c = key_valid; key_op_c = 2'b10; end
      8'h28:   begin is_op_c = key_valid; key_op_c = 2'b11; end
      default: ;
    endcase
    digit_c     = OPND_W'(key_code[3:0]);
    acc_c       = ((state == S_B) ? b : a) * 7'd10 + digit_c;
    small_res_c = (disp_value <= 14'd99);
  end

  // Clear behaves exactly like reset and beats a simultaneous alu_done
  always_ff @(posedge clk) begin
    if (rst || is_clr_c) begin
      state      <= S_A;
      cnt        <= 2'd0;
      a          <= '0;
      b          <= '0;
      op         <= '0;
      neg        <= 1'b0;
      tmr        <= '0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      disp_value <= '0;
      disp_neg   <= 1'b0;
      disp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        S_A, S_B: begin
          if (is_digit_c) begin
            if (cnt == 2'd0) begin
              if (state == S_A) a <= digit_c; else b <= digit_c;
              disp_value <= RES_W'(digit_c);
              cnt        <= 2'd1;
            end else if (cnt == 2'd1) begin
              if (state == S_A) a <= acc_c; else b <= acc_c;
              disp_value <= RES_W'(acc_c);
              cnt        <= 2'd2;
            end
          end else if (is_op_c) begin
            if (state == S_A && cnt != 2'd0) begin
              op    <= key_op_c;
              b     <= '0;
              cnt   <= 2'd0;
              state <= S_B;
            end else if (state == S_B && cnt == 2'd0) begin
              op <= key_op_c;
            end
          end else if (is_eq_c && state == S_B && cnt != 2'd0) begin
            state     <= S_EXEC;
            busy      <= 1'b1;
            alu_start <= 1'b1;
            tmr       <= '0;
            alu_op    <= op;
            // Subtraction is always issued as big-minus-small; the sign is kept locally
            if (op == 2'b01 && a < b) begin
              alu_a <= b;
              alu_b <= a;
              neg   <= 1'b1;
            end else begin
              alu_a <= a;
              alu_b <= b;
              neg   <= 1'b0;
            end
          end
        end
        S_EXEC: begin
          if (alu_done) begin
            busy <= 1'b0;
            if (alu_err) begin
              state      <= S_ERR;
              disp_err   <= 1'b1;
              disp_value <= '0;
              disp_neg   <= 1'b0;
            end else begin
              state      <= S_SHOW;
              disp_value <= alu_result;
              disp_neg   <= neg;
            end
          end else if (tmr == TMR_LAST) begin
            state      <= S_ERR;
            busy       <= 1'b0;
            disp_err   <= 1'b1;
            disp_value <= '0;
            disp_neg   <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_SHOW: begin
          if (is_digit_c) begin
            a          <= digit_c;
            b          <= '0;
            cnt        <= 2'd1;
            disp_value <= RES_W'(digit_c);
            disp_neg   <= 1'b0;
            state      <= S_A;
          end else if (is_op_c && small_res_c && !neg) begin
            // Chain: the small non-negative result becomes operand A
            a     <= disp_value[OPND_W-1:0];
            b     <= '0;
            op    <= key_op_c;
            cnt   <= 2'd0;
            state <= S_B;
          end
        end
        S_ERR: ;
        default: state <= S_A;
      endcase
    end
  end

endmodule
